// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: grant/rw levels,
// FSM state encoding and default bus widths.
package bus_rr_arbiter_pkg;

   localparam int BUS_ADDR_WIDTH = 16;
   localparam int DATA_WIDTH     = 16;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;
   localparam logic READ     = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first requester after ptr, wrapping mod NREQ.
// Masters in excl are skipped unless nobody else is requesting.
module rr_pick #(
   parameter int NREQ  = 4,
   parameter int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   input  logic [NREQ-1:0]  excl,
   output logic             valid,
   output logic [PTR_W-1:0] idx
);

   logic [NREQ-1:0] cand;
   int              pos;

   always_comb begin
      cand  = ((req & ~excl) != '0) ? (req & ~excl) : req;
      valid = |cand;
      idx   = '0;
      pos   = 0;
      // Walk from farthest to nearest so the slot right after ptr wins.
      for (int k = NREQ; k >= 1; k--) begin
         pos = (int'(ptr) + k) % NREQ;
         if (cand[pos]) idx = pos[PTR_W-1:0];
      end
   end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter and bus mux for the shared slave bus, with bounded
// tenure so a streaming master cannot starve the others.
//
// state | meaning
// IDLE  | no grant; arbitrate, grant on next edge
// GRANT | bgrt_[owner] low, tenure counter running
// TURN  | one turnaround cycle with all grants high; arbitrate again
module bus_rr_arbiter
   import bus_rr_arbiter_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int ADDR_W   = BUS_ADDR_WIDTH,
   parameter int DATA_W   = DATA_WIDTH,
   parameter int MAX_HOLD = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        breq_,
   input  logic [NREQ*ADDR_W-1:0] addr_in,
   input  logic [NREQ*DATA_W-1:0] idata_in,
   input  logic [NREQ-1:0]        rw_in_,
   output logic [NREQ-1:0]        bgrt_,
   output logic [ADDR_W-1:0]      addr,
   output logic [DATA_W-1:0]      idata,
   output logic                   rw_,
   output logic [2:0]             owner,
   output logic                   busy
);

   localparam int PTR_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MAX_HOLD - 1);

   arb_state_e       state_q, state_d;
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [NREQ-1:0]  bgrt_q, bgrt_d;

   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  owner_oh;
   logic [NREQ-1:0]  excl;
   logic             pick_valid;
   logic [PTR_W-1:0] pick_idx;

   assign req      = ~breq_;
   assign owner_oh = NREQ'(1) << owner_q;
   assign excl     = (state_q == TURN) ? owner_oh : '0;

   rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .excl  (excl),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= PTR_W'(NREQ - 1);
         hold_q  <= '0;
         bgrt_q  <= {NREQ{DISABLE_}};
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         bgrt_q  <= bgrt_d;
      end
   end

   // hold_q counts remaining tenure down; zero means the owner may be preempted.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = (hold_q != '0) ? hold_q - CNT_W'(1) : hold_q;
      bgrt_d  = bgrt_q;
      case (state_q)
         IDLE, TURN: begin
            bgrt_d = {NREQ{DISABLE_}};
            if (pick_valid) begin
               state_d          = GRANT;
               owner_d          = pick_idx;
               ptr_d            = pick_idx;
               hold_d           = HOLD_LOAD;
               bgrt_d[pick_idx] = ENABLE_;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (!req[owner_q] || (hold_q == '0 && (req & ~owner_oh) != '0)) begin
               state_d = TURN;
               bgrt_d  = {NREQ{DISABLE_}};
            end
         end
         default: begin
            state_d = IDLE;
            bgrt_d  = {NREQ{DISABLE_}};
         end
      endcase
   end

   assign busy  = (state_q == GRANT);
   assign bgrt_ = bgrt_q;
   assign owner = 3'(owner_q);
   // Idle bus parks on read so slaves never see a stray write.
   assign addr  = busy ? addr_in[owner_q*ADDR_W +: ADDR_W]  : '0;
   assign idata = busy ? idata_in[owner_q*DATA_W +: DATA_W] : '0;
   assign rw_   = busy ? rw_in_[owner_q] : READ;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: reset, lone requester, rotation with
// tenure limit, bus mux steering, release at terminal count, reset mid-grant.
module tb_bus_rr_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 16;
   localparam int DW   = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   breq_;
   logic [NREQ*AW-1:0] addr_in;
   logic [NREQ*DW-1:0] idata_in;
   logic [NREQ-1:0]   rw_in_;
   logic [NREQ-1:0]   bgrt_;
   logic [AW-1:0]     addr;
   logic [DW-1:0]     idata;
   logic              rw_;
   logic [2:0]        owner;
   logic              busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   bus_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .breq_    (breq_),
      .addr_in  (addr_in),
      .idata_in (idata_in),
      .rw_in_   (rw_in_),
      .bgrt_    (bgrt_),
      .addr     (addr),
      .idata    (idata),
      .rw_      (rw_),
      .owner    (owner),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      breq_ = 4'b1111;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      breq_    = 4'b0000;
      addr_in  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      idata_in = '0;
      rw_in_   = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++;
         if (bgrt_ !== 4'b1111 || rw_ !== 1'b1 || busy !== 1'b0 || owner !== 3'd0 || addr !== 16'h0)
            $display("FAIL reset_hold[%0d]: bgrt_=%b rw_=%b busy=%b owner=%0d addr=%h, expected 1111/1/0/0/0000",
                     i, bgrt_, rw_, busy, owner, addr);
         else pass_cnt++;
      end
      reset = 1'b0;
      step();
      total_cnt++;
      if (bgrt_ !== 4'b1110 || owner !== 3'd0 || busy !== 1'b1 || addr !== 16'h1111 || rw_ !== 1'b0)
         $display("FAIL reset_first_grant: bgrt_=%b owner=%0d busy=%b addr=%h rw_=%b, expected 1110/0/1/1111/0",
                  bgrt_, owner, busy, addr, rw_);
      else pass_cnt++;
   endtask

   task automatic test_lone_requester();
      int bad = 0;
      apply_reset();
      breq_ = 4'b1011;
      step();
      for (int i = 0; i < 40; i++) begin
         if (bgrt_ !== 4'b1011 || owner !== 3'd2) bad++;
         step();
      end
      total_cnt++;
      if (bad != 0) $display("FAIL lone_no_preempt: %0d bad cycles, expected 0", bad);
      else pass_cnt++;
      breq_ = 4'b1111;
      step();
      total_cnt++;
      if (bgrt_ !== 4'b1111 || busy !== 1'b0)
         $display("FAIL lone_release: bgrt_=%b busy=%b, expected 1111/0", bgrt_, busy);
      else pass_cnt++;
      step();
      total_cnt++;
      if (bgrt_ !== 4'b1111 || busy !== 1'b0)
         $display("FAIL lone_idle: bgrt_=%b busy=%b, expected 1111/0", bgrt_, busy);
      else pass_cnt++;
   endtask

   task automatic test_rotation();
      logic [NREQ-1:0] exp_g;
      int phase;
      apply_reset();
      breq_ = 4'b0000;
      for (int n = 1; n <= 69; n++) begin
         step();
         phase = (n - 1) % 17;
         exp_g = 4'b1111;
         if (phase < 16) exp_g[((n - 1) / 17) % 4] = 1'b0;
         total_cnt++;
         if (bgrt_ !== exp_g)
            $display("FAIL rotation[cycle %0d]: bgrt_=%b, expected %b", n, bgrt_, exp_g);
         else pass_cnt++;
      end
   endtask

   task automatic test_mux();
      apply_reset();
      addr_in  = {16'hFFFF, 16'hxxxx, 16'h0040, 16'hxxxx};
      idata_in = {16'hDEAD, 16'hxxxx, 16'h1234, 16'hxxxx};
      rw_in_   = 4'b1x0x;
      total_cnt++;
      if (addr !== 16'h0 || idata !== 16'h0 || rw_ !== 1'b1)
         $display("FAIL mux_idle: addr=%h idata=%h rw_=%b, expected 0000/0000/1", addr, idata, rw_);
      else pass_cnt++;
      breq_ = 4'b0101;
      step();
      total_cnt++;
      if (bgrt_ !== 4'b1101 || addr !== 16'h0040 || idata !== 16'h1234 || rw_ !== 1'b0)
         $display("FAIL mux_m1: bgrt_=%b addr=%h idata=%h rw_=%b, expected 1101/0040/1234/0",
                  bgrt_, addr, idata, rw_);
      else pass_cnt++;
      addr_in[3*AW +: AW] = 16'hxxxx;
      #1;
      total_cnt++;
      if (addr !== 16'h0040)
         $display("FAIL mux_isolation: addr=%h, expected 0040", addr);
      else pass_cnt++;
      addr_in[3*AW +: AW] = 16'hFFFF;
      breq_ = 4'b0111;
      step();
      total_cnt++;
      if (bgrt_ !== 4'b1111 || addr !== 16'h0 || rw_ !== 1'b1)
         $display("FAIL mux_turn: bgrt_=%b addr=%h rw_=%b, expected 1111/0000/1", bgrt_, addr, rw_);
      else pass_cnt++;
      step();
      total_cnt++;
      if (bgrt_ !== 4'b0111 || owner !== 3'd3 || addr !== 16'hFFFF || idata !== 16'hDEAD || rw_ !== 1'b1)
         $display("FAIL mux_m3: bgrt_=%b owner=%0d addr=%h idata=%h rw_=%b, expected 0111/3/FFFF/DEAD/1",
                  bgrt_, owner, addr, idata, rw_);
      else pass_cnt++;
   endtask

   task automatic test_release_at_limit();
      apply_reset();
      breq_ = 4'b1110;
      for (int i = 0; i < 16; i++) step();
      total_cnt++;
      if (bgrt_ !== 4'b1110)
         $display("FAIL limit_held: bgrt_=%b, expected 1110", bgrt_);
      else pass_cnt++;
      breq_ = 4'b0111;
      step();
      total_cnt++;
      if (bgrt_ !== 4'b1111 || busy !== 1'b0)
         $display("FAIL limit_turn: bgrt_=%b busy=%b, expected 1111/0", bgrt_, busy);
      else pass_cnt++;
      step();
      total_cnt++;
      if (bgrt_ !== 4'b0111 || owner !== 3'd3)
         $display("FAIL limit_next: bgrt_=%b owner=%0d, expected 0111/3", bgrt_, owner);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_grant();
      apply_reset();
      breq_ = 4'b1011;
      for (int i = 0; i < 8; i++) step();
      total_cnt++;
      if (bgrt_ !== 4'b1011 || owner !== 3'd2)
         $display("FAIL midrst_pre: bgrt_=%b owner=%0d, expected 1011/2", bgrt_, owner);
      else pass_cnt++;
      reset = 1'b1;
      breq_ = 4'b0000;
      step();
      total_cnt++;
      if (bgrt_ !== 4'b1111 || busy !== 1'b0 || owner !== 3'd0)
         $display("FAIL midrst_clear: bgrt_=%b busy=%b owner=%0d, expected 1111/0/0", bgrt_, busy, owner);
      else pass_cnt++;
      reset = 1'b0;
      step();
      total_cnt++;
      if (bgrt_ !== 4'b1110 || owner !== 3'd0)
         $display("FAIL midrst_first: bgrt_=%b owner=%0d, expected 1110/0", bgrt_, owner);
      else pass_cnt++;
   endtask

   initial begin
      reset    = 1'b1;
      breq_    = 4'b1111;
      addr_in  = '0;
      idata_in = '0;
      rw_in_   = '1;
      test_reset();
      test_lone_requester();
      test_rotation();
      test_mux();
      test_release_at_limit();
      test_reset_mid_grant();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
